// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART word sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxLoad,
    StTxWait,
    StRxArm,
    StRxWait,
    StResp,
    StError
  } seq_state_e;

  localparam logic [1:0]  UART_SEL_DEFAULT = 2'b10;
  localparam int unsigned BYTE_CNT_W       = 2;
  localparam int unsigned WORD_W           = 32;

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = '1;

  // Replace byte lane `lane` of `word` with `data`.
  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0]     word,
                                                 input logic [BYTE_CNT_W-1:0] lane,
                                                 input logic [7:0]            data);
    logic [WORD_W-1:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = data;
    return r;
  endfunction

endpackage

// File: rtl/uart_seq_if.sv
// APB-side and UART-side signals of the word sequencer, grouped into one bundle.
interface uart_seq_if;
  import uart_seq_pkg::*;

  logic [1:0]        psel;
  logic              pen;
  logic              pwr;
  logic [WORD_W-1:0] pwData;
  logic [WORD_W-1:0] prdata;
  logic              pready;
  logic              err_out;
  logic              txStart;
  logic [7:0]        txData;
  logic              tx_en;
  logic              txDone;
  logic              busy;
  logic              rxStart;
  logic              rx_en;
  logic [7:0]        rxData;
  logic              rxDone;
  logic              err_in;

  // Environment side: APB master plus the UART TX/RX cores.
  modport master (
    output psel, pen, pwr, pwData, txDone, busy, rxData, rxDone, err_in,
    input  prdata, pready, err_out, txStart, txData, tx_en, rxStart, rx_en
  );

  // Sequencer side.
  modport slave (
    input  psel, pen, pwr, pwData, txDone, busy, rxData, rxDone, err_in,
    output prdata, pready, err_out, txStart, txData, tx_en, rxStart, rx_en
  );

endinterface

// File: rtl/uart_seq_timer.sv
// Per-byte wait timer: cleared on state entry, counts while enabled, flags TIMEOUT-1.
module uart_seq_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_sequencer.sv
// APB-to-UART word sequencer: a write goes out as four LSB-first TX bytes, a read collects
// four RX bytes into prdata; per-byte timeout and err_in end the transfer with an error.
module uart_word_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [1:0]  UART_SEL = UART_SEL_DEFAULT,
  parameter int unsigned TIMEOUT  = 65535
) (
  input logic       clk,
  input logic       rst_n,
  uart_seq_if.slave bus
);

  seq_state_e            state_q, state_d;
  logic [WORD_W-1:0]     shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]     prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  err_q, err_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  rx_start_q, rx_start_d;
  logic                  rx_en_q, rx_en_d;
  logic                  timer_clr, timer_en, timer_exp;
  logic                  last_byte;

  assign last_byte = (cnt_q == LAST_BYTE);
  assign timer_en  = (state_q == StTxLoad) || (state_q == StTxWait) || (state_q == StRxWait);
  // Any state change restarts the wait budget for the state being entered.
  assign timer_clr = (state_d != state_q);

  uart_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    prdata_d   = '0;
    tx_start_d = 1'b0;
    rx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.psel == UART_SEL && bus.pen) begin
          cnt_d = '0;
          if (bus.pwr) begin
            shift_d = bus.pwData;
            state_d = StTxLoad;
          end else begin
            shift_d = '0;
            state_d = StRxArm;
          end
        end
      end
      StTxLoad: begin
        if (bus.err_in) begin
          state_d = StError;
        end else if (!bus.busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[7:0];
          state_d    = StTxWait;
        end else if (timer_exp) begin
          state_d = StError;
        end
      end
      StTxWait: begin
        if (bus.err_in) begin
          state_d = StError;
        end else if (bus.txDone) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + BYTE_CNT_W'(1);
          state_d = last_byte ? StResp : StTxLoad;
        end else if (timer_exp) begin
          state_d = StError;
        end
      end
      StRxArm: begin
        if (bus.err_in) begin
          state_d = StError;
        end else begin
          rx_start_d = 1'b1;
          state_d    = StRxWait;
        end
      end
      StRxWait: begin
        if (bus.err_in) begin
          state_d = StError;
        end else if (bus.rxDone) begin
          shift_d = put_byte(shift_q, cnt_q, bus.rxData);
          cnt_d   = cnt_q + BYTE_CNT_W'(1);
          if (last_byte) begin
            prdata_d = shift_d;
            state_d  = StResp;
          end else begin
            state_d = StRxArm;
          end
        end else if (timer_exp) begin
          state_d = StError;
        end
      end
      StResp, StError: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the state being entered, so nothing is combinational
    // from an input pin to an output pin.
    pready_d = (state_d == StResp) || (state_d == StError);
    err_d    = (state_d == StError);
    tx_en_d  = (state_d == StTxLoad) || (state_d == StTxWait);
    rx_en_d  = (state_d == StRxArm) || (state_d == StRxWait);
    if (!tx_en_d) begin
      tx_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      rx_start_q <= 1'b0;
      rx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      rx_start_q <= rx_start_d;
      rx_en_q    <= rx_en_d;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.err_out = err_q;
  assign bus.txStart = tx_start_q;
  assign bus.txData  = tx_data_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.rxStart = rx_start_q;
  assign bus.rx_en   = rx_en_q;

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Bench for uart_word_sequencer: table vectors, random transfers against a word-level
// reference model, and hand-written reset / ignored-select sequences.
module tb_uart_word_sequencer;
  import uart_seq_pkg::*;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [1:0]  SEL     = 2'b10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_seq_if bus_if ();

  uart_word_sequencer #(
    .UART_SEL (SEL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outcome of one transfer. Cycle numbers count falling edges after the one at
  // which the request is driven.
  typedef struct {
    int          starts;
    int          first;
    int          pready_cyc;
    logic        err;
    logic [31:0] prdata;
    logic [31:0] tx_word;
  } exp_t;

  typedef struct {
    int          tx_starts;
    int          rx_starts;
    int          first_start;
    int          gap_err;
    int          stab_err;
    int          pready_cyc;
    logic        err;
    logic [31:0] prdata;
    logic [31:0] tx_word;
    logic        en_at_resp;
    logic        pready_after;
  } res_t;

  typedef struct {
    logic        wr;
    logic [31:0] word;
    int          busy_hold;
    int          dly;
    int          err_byte;
    exp_t        exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'h0, bus_if.prdata, bus_if.pready, bus_if.err_out, bus_if.txStart,
            bus_if.txData, bus_if.tx_en, bus_if.rxStart, bus_if.rx_en};
  endfunction

  // Word-level model: bytes go one per start, each start dly cycles before its done and
  // the next start two cycles after that done; busy only delays the first byte.
  function automatic exp_t model(input logic wr, input logic [31:0] word, input int busy_hold,
                                 input int dly, input int err_byte);
    exp_t e;
    int   first;
    int   nbytes;
    first = wr ? ((busy_hold > 1 ? busy_hold : 1) + 1) : 2;
    if (wr && busy_hold > int'(TIMEOUT)) begin
      e.starts     = 0;
      e.first      = -1;
      e.pready_cyc = TIMEOUT + 1;
      e.err        = 1'b1;
    end else begin
      nbytes       = (err_byte >= 0 && err_byte < 4) ? err_byte + 1 : 4;
      e.starts     = nbytes;
      e.first      = first;
      e.err        = (err_byte >= 0 && err_byte < 4);
      e.pready_cyc = first + (nbytes - 1) * (dly + 2) + dly + 1;
    end
    e.prdata  = (!wr && !e.err) ? word : 32'h0;
    e.tx_word = 32'h0;
    if (wr) begin
      for (int k = 0; k < e.starts; k++) e.tx_word[8*k +: 8] = word[8*k +: 8];
    end
    return e;
  endfunction

  // Issue one APB transfer and play the UART cores; rst_at>0 pulls rst_n low right after
  // that many txStart pulses have been seen.
  task automatic run_txn(input logic wr, input logic [31:0] word, input int busy_hold,
                         input int dly, input int err_byte, input int rst_at, output res_t r);
    int       cd, nb, last_done, c;
    logic [7:0] held;
    logic     start, prev_start, stop;
    r.tx_starts = 0;  r.rx_starts = 0;  r.first_start = -1; r.gap_err = 0; r.stab_err = 0;
    r.pready_cyc = -1; r.err = 1'b0; r.prdata = '0; r.tx_word = '0; r.en_at_resp = 1'b0;
    r.pready_after = 1'b0;
    cd = 0; nb = 0; last_done = 0; c = 0; held = '0; prev_start = 1'b0; stop = 1'b0;
    @(negedge clk);
    bus_if.psel = SEL; bus_if.pen = 1'b1; bus_if.pwr = wr; bus_if.pwData = word;
    bus_if.busy = (busy_hold > 0);
    while (!stop && c < 300) begin
      @(negedge clk);
      c++;
      bus_if.psel = 2'b00; bus_if.pen = 1'b0; bus_if.pwr = 1'b0;
      bus_if.txDone = 1'b0; bus_if.rxDone = 1'b0; bus_if.err_in = 1'b0;
      bus_if.busy = (c < busy_hold);
      if (rst_at > 0 && r.tx_starts == rst_at) begin
        rst_n = 1'b0;
        stop  = 1'b1;
      end else begin
        if (bus_if.pready) begin
          r.pready_cyc = c;
          r.err        = bus_if.err_out;
          r.prdata     = bus_if.prdata;
          r.en_at_resp = bus_if.tx_en | bus_if.rx_en;
          stop         = 1'b1;
        end
        start = wr ? bus_if.txStart : bus_if.rxStart;
        if (start && prev_start) r.gap_err++;
        prev_start = start;
        if (cd > 0) begin
          if (wr && bus_if.txData !== held) r.stab_err++;
          cd--;
          if (cd == 0) begin
            if (wr) begin
              bus_if.txDone = 1'b1;
            end else begin
              bus_if.rxDone = 1'b1;
              bus_if.rxData = word[8*nb +: 8];
            end
            if (nb == err_byte) bus_if.err_in = 1'b1;
            nb++;
            last_done = c;
          end
        end
        if (bus_if.txStart) begin
          if (r.tx_starts < 4) r.tx_word[8*r.tx_starts +: 8] = bus_if.txData;
          r.tx_starts++;
        end
        if (bus_if.rxStart) r.rx_starts++;
        if (start) begin
          if (r.first_start < 0) r.first_start = c;
          else if (c != last_done + 2) r.gap_err++;
          cd   = dly;
          held = bus_if.txData;
        end
      end
    end
    if (rst_at == 0) begin
      @(negedge clk);
      r.pready_after = bus_if.pready;
      bus_if.busy    = 1'b0;
    end
  endtask

  task automatic check_res(input string tag, input logic wr, input res_t r, input exp_t e);
    check({tag, ".err_out"},    r.err,          e.err);
    check({tag, ".prdata"},     r.prdata,       e.prdata);
    check({tag, ".tx_starts"},  r.tx_starts,    wr ? e.starts : 0);
    check({tag, ".rx_starts"},  r.rx_starts,    wr ? 0 : e.starts);
    check({tag, ".first"},      r.first_start,  e.first);
    check({tag, ".pready_cyc"}, r.pready_cyc,   e.pready_cyc);
    check({tag, ".tx_bytes"},   r.tx_word,      e.tx_word);
    check({tag, ".gaps"},       r.gap_err,      0);
    check({tag, ".txdata_hold"}, r.stab_err,    0);
    check({tag, ".en_at_resp"}, r.en_at_resp,   1'b0);
    check({tag, ".pready_len"}, r.pready_after, 1'b0);
  endtask

  initial begin
    vec_t  vecs[8];
    res_t  r;
    exp_t  e;
    int    bad;
    logic  wr;
    logic [31:0] word;
    int    busy_hold, dly, err_byte;

    vecs[0] = '{1'b1, 32'hA1B2C3D4,  0, 3, -1, '{4,  2, 21, 1'b0, 32'h0,        32'hA1B2C3D4}};
    vecs[1] = '{1'b0, 32'h44332211,  0, 2, -1, '{4,  2, 17, 1'b0, 32'h44332211, 32'h0}};
    vecs[2] = '{1'b1, 32'h12345678, 10, 1, -1, '{4, 11, 22, 1'b0, 32'h0,        32'h12345678}};
    vecs[3] = '{1'b1, 32'h0BADF00D, 20, 1, -1, '{0, -1, 17, 1'b1, 32'h0,        32'h0}};
    vecs[4] = '{1'b0, 32'hCAFEF00D,  0, 2,  1, '{2,  2,  9, 1'b1, 32'h0,        32'h0}};
    vecs[5] = '{1'b1, 32'h89ABCDEF,  0, 1,  0, '{1,  2,  4, 1'b1, 32'h0,        32'h000000EF}};
    vecs[6] = '{1'b1, 32'h5A5A5A5A, 16, 2, -1, '{4, 17, 32, 1'b0, 32'h0,        32'h5A5A5A5A}};
    vecs[7] = '{1'b1, 32'h0F0F0F0F, 17, 2, -1, '{0, -1, 17, 1'b1, 32'h0,        32'h0}};

    bus_if.psel = 2'b00; bus_if.pen = 1'b0; bus_if.pwr = 1'b0; bus_if.pwData = '0;
    bus_if.txDone = 1'b0; bus_if.busy = 1'b0; bus_if.rxData = '0; bus_if.rxDone = 1'b0;
    bus_if.err_in = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.outputs", outs(), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].wr, vecs[i].word, vecs[i].busy_hold, vecs[i].dly, vecs[i].err_byte, 0, r);
      check_res($sformatf("vec%0d", i), vecs[i].wr, r, vecs[i].exp);
    end

    // Reset while the third byte of a write is in flight.
    run_txn(1'b1, 32'hDEADBEEF, 0, 3, -1, 3, r);
    @(negedge clk);
    check("rst_mid.outputs", outs(), 64'h0);
    check("rst_mid.tx_starts", r.tx_starts, 3);
    rst_n = 1'b1;
    run_txn(1'b1, 32'h00000055, 0, 2, -1, 0, r);
    check_res("after_rst", 1'b1, r, model(1'b1, 32'h00000055, 0, 2, -1));

    // Requests for other slaves must be ignored.
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus_if.psel = (c % 3 == 0) ? 2'b01 : ((c % 3 == 1) ? 2'b11 : 2'b00);
      bus_if.pen  = 1'b1;
      bus_if.pwr  = c[0];
      if (bus_if.txStart | bus_if.rxStart | bus_if.pready | bus_if.tx_en | bus_if.rx_en) bad++;
    end
    @(negedge clk);
    bus_if.psel = 2'b00; bus_if.pen = 1'b0;
    if (bus_if.txStart | bus_if.rxStart | bus_if.pready | bus_if.tx_en | bus_if.rx_en) bad++;
    check("ignore_sel", bad, 0);

    for (int i = 0; i < 24; i++) begin
      wr        = 1'($urandom_range(0, 1));
      word      = $urandom;
      dly       = $urandom_range(1, 5);
      busy_hold = wr ? $urandom_range(0, 4) : 0;
      err_byte  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      e = model(wr, word, busy_hold, dly, err_byte);
      run_txn(wr, word, busy_hold, dly, err_byte, 0, r);
      check_res($sformatf("rnd%0d", i), wr, r, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
